stepper_move_sequencer: RTL and testbench

STEPPER_MOVE_SEQUENCER -- requirements
Module: stepper_move_sequencer

---
 rtl/constants.sv | 15 +
 rtl/stepper_move_sequencer_if.sv | 33 +++
 rtl/cycle_timer.sv | 35 +++
 rtl/stepper_move_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stepper_move_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/constants.sv
// Shared constants and FSM state encoding for the stepper move sequencer.
package constants;

    localparam int STEPPER_PULSE_WIDTH = 256;
    localparam int STEPPER_DIR_SETUP   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// Move request / motor driver signal bundle between a controller and the sequencer.
// Handshake: start_i is a single-cycle request accepted only while busy_o=0 and the
// sequencer is idle; done_o is a single-cycle completion strobe; no backpressure.
interface stepper_move_sequencer_if #(
    parameter int g_CountBits = 16
);
    import constants::*;

    logic                   start_i;
    logic                   abort_i;
    logic                   fail_i;
    logic [g_CountBits-1:0] steps_i;
    logic [g_CountBits-1:0] period_i;
    logic                   dir_i;
    logic                   step_o;
    logic                   dir_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   error_o;
    logic [g_CountBits-1:0] steps_done_o;
    state_t                 state_o;

    modport master (
        output start_i, abort_i, fail_i, steps_i, period_i, dir_i,
        input  step_o, dir_o, busy_o, done_o, error_o, steps_done_o, state_o
    );

    modport slave (
        input  start_i, abort_i, fail_i, steps_i, period_i, dir_i,
        output step_o, dir_o, busy_o, done_o, error_o, steps_done_o, state_o
    );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire_o flags the last cycle of a loaded interval.
module cycle_timer #(
    parameter int g_Width = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               load_i,
    input  logic [g_Width-1:0] value_i,
    output logic               expire_o
);

    logic [g_Width-1:0] count_q;
    logic [g_Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of 0 or 1 both give a one-cycle interval.
    assign expire_o = (count_q <= g_Width'(1));

endmodule

// File: rtl/stepper_move_sequencer.sv
// Issues a counted train of fixed-width step pulses after a direction setup time,
// with abort/fault handling that never truncates a pulse in flight.
module stepper_move_sequencer
    import constants::*;
#(
    parameter int g_PulseWidth = STEPPER_PULSE_WIDTH,
    parameter int g_DirSetup   = STEPPER_DIR_SETUP,
    parameter int g_CountBits  = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    stepper_move_sequencer_if.slave bus
);

    localparam logic [g_CountBits-1:0] PulseCnt  = g_CountBits'(g_PulseWidth);
    localparam logic [g_CountBits-1:0] SetupCnt  = g_CountBits'(g_DirSetup);
    localparam logic [g_CountBits-1:0] MinPeriod = g_CountBits'(g_PulseWidth + 1);

    state_t                 state_q, state_d;
    logic [g_CountBits-1:0] steps_q, steps_d;
    logic [g_CountBits-1:0] period_q, period_d;
    logic [g_CountBits-1:0] cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   stop_q, stop_d;
    logic                   fail_q, fail_d;

    logic                   tmr_load;
    logic [g_CountBits-1:0] tmr_value;
    logic                   tmr_expire;
    logic                   finish;
    logic                   finish_fail;

    cycle_timer #(.g_Width(g_CountBits)) u_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        step_d      = step_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        stop_d      = stop_q;
        fail_d      = fail_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        finish      = 1'b0;
        finish_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    steps_d   = bus.steps_i;
                    period_d  = (bus.period_i < MinPeriod) ? MinPeriod : bus.period_i;
                    dir_d     = bus.dir_i;
                    cnt_d     = '0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    // A fault already present at the request ends the move in SETUP.
                    stop_d    = bus.fail_i;
                    fail_d    = bus.fail_i;
                    state_d   = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_value = SetupCnt;
                end
            end
            ST_SETUP: begin
                if (steps_q == '0 || stop_q || bus.abort_i || bus.fail_i) begin
                    finish      = 1'b1;
                    finish_fail = fail_q | bus.fail_i;
                end else if (tmr_expire) begin
                    state_d   = ST_PULSE;
                    step_d    = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = PulseCnt;
                end
            end
            ST_PULSE: begin
                // Stop requests are remembered until the pulse has run its full width.
                stop_d = stop_q | bus.abort_i | bus.fail_i;
                fail_d = fail_q | bus.fail_i;
                if (tmr_expire) begin
                    step_d = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                    if (stop_d) begin
                        finish      = 1'b1;
                        finish_fail = fail_d;
                    end else begin
                        state_d   = ST_GAP;
                        tmr_load  = 1'b1;
                        tmr_value = period_q - PulseCnt;
                    end
                end
            end
            ST_GAP: begin
                if (bus.abort_i || bus.fail_i) begin
                    finish      = 1'b1;
                    finish_fail = bus.fail_i;
                end else if (tmr_expire) begin
                    if (cnt_q < steps_q) begin
                        state_d   = ST_PULSE;
                        step_d    = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_value = PulseCnt;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (finish_fail) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            steps_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            stop_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            steps_q  <= steps_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            stop_q   <= stop_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.step_o       = step_q;
    assign bus.dir_o        = dir_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.error_o      = error_q;
    assign bus.steps_done_o = cnt_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed and random moves against a timeline model
// that derives pulse windows and the finishing cycle arithmetically from the move rules.
module tb_stepper_move_sequencer;
    import constants::*;

    localparam int PW = 4;
    localparam int DS = 2;
    localparam int CB = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    stepper_move_sequencer_if #(.g_CountBits(CB)) bus();

    stepper_move_sequencer #(
        .g_PulseWidth (PW),
        .g_DirSetup   (DS),
        .g_CountBits  (CB)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs: {step, busy, done, error, dir, steps_done}.
    logic [20:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start_i  = 1'b0;
        bus.abort_i  = 1'b0;
        bus.fail_i   = 1'b0;
        bus.steps_i  = '0;
        bus.period_i = '0;
        bus.dir_i    = 1'b0;
    endtask

    // kind: 0 none, 1 abort, 2 fail, 3 abort+fail, raised for the single cycle s
    // (cycle 0 is the start_i cycle). ign requests a stray start_i while busy.
    task automatic run_move(input int n, input int p, input bit d, input int s,
                            input int kind, input bit ign);
        int          pe, norm, done_c, off, k, r, cnt, b;
        bit          is_fail, err, hi;
        logic [20:0] e;

        pe      = (p < PW + 1) ? PW + 1 : p;
        is_fail = (kind >= 2);
        norm    = (n == 0) ? 2 : 1 + DS + n * pe;
        done_c  = norm;
        err     = 1'b0;
        if (kind != 0 && s == 0 && is_fail) begin
            done_c = 2;
            err    = 1'b1;
        end else if (kind != 0 && s >= 1 && s < norm) begin
            off = s - (1 + DS);
            if (off < 0) begin
                done_c = s + 1;
            end else begin
                k      = off / pe;
                done_c = ((off % pe) < PW) ? (1 + DS + k * pe + PW) : s + 1;
            end
            err = is_fail;
        end
        b = ign ? $urandom_range(1, done_c - 1) : 0;

        exp_q.delete();
        for (int t = 1; t <= done_c + 2; t++) begin
            hi  = 1'b0;
            cnt = 0;
            for (int j = 0; j < n; j++) begin
                r = 1 + DS + j * pe;
                if (t >= r && t < r + PW && t < done_c) hi = 1'b1;
                if (r + PW <= t && r + PW <= done_c) cnt++;
            end
            e = {hi, (t < done_c), (t == done_c), (err && t >= done_c), d, CB'(cnt)};
            exp_q.push_back(e);
        end

        @(posedge clk);
        #1;
        bus.start_i  = 1'b1;
        bus.steps_i  = CB'(n);
        bus.period_i = CB'(p);
        bus.dir_i    = d;
        bus.abort_i  = (kind == 1 || kind == 3) && s == 0;
        bus.fail_i   = (kind >= 2) && s == 0;
        for (int t = 1; t <= done_c + 2; t++) begin
            @(posedge clk);
            #1;
            bus.start_i  = (t == b);
            bus.steps_i  = CB'($urandom_range(0, 9));
            bus.period_i = CB'($urandom_range(0, 20));
            bus.dir_i    = $urandom_range(0, 1);
            bus.abort_i  = (kind == 1 || kind == 3) && s == t;
            bus.fail_i   = (kind >= 2) && s == t;
            @(negedge clk);
            e = exp_q.pop_front();
            check("step_o",       bus.step_o,       e[20]);
            check("busy_o",       bus.busy_o,       e[19]);
            check("done_o",       bus.done_o,       e[18]);
            check("error_o",      bus.error_o,      e[17]);
            check("dir_o",        bus.dir_o,        e[16]);
            check("steps_done_o", bus.steps_done_o, e[15:0]);
        end
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"},  bus.step_o,       0);
        check({tag, "_dir"},   bus.dir_o,        0);
        check({tag, "_busy"},  bus.busy_o,       0);
        check({tag, "_done"},  bus.done_o,       0);
        check({tag, "_error"}, bus.error_o,      0);
        check({tag, "_count"}, bus.steps_done_o, 0);
        check({tag, "_state"}, bus.state_o,      ST_IDLE);
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_move(3, 10, 1'b1, 0, 0, 1'b0);   // nominal three-step move
        run_move(0, 7,  1'b0, 0, 0, 1'b0);   // zero steps
        run_move(3, 2,  1'b1, 0, 0, 1'b0);   // period clamped to PW+1
        run_move(3, 10, 1'b0, 14, 1, 1'b0);  // abort mid second pulse
        run_move(3, 10, 1'b1, 8, 3, 1'b0);   // abort+fail in first gap
        run_move(2, 6,  1'b0, 0, 0, 1'b1);   // error cleared, stray start ignored
        run_move(2, 6,  1'b1, 0, 2, 1'b0);   // fault present at start
        run_move(2, 6,  1'b1, 1, 1, 1'b0);   // abort during setup
        run_move(2, 6,  1'b0, 0, 1, 1'b0);   // abort at start has no effect

        // Reset asserted during the first pulse.
        @(posedge clk);
        #1;
        bus.start_i  = 1'b1;
        bus.steps_i  = CB'(3);
        bus.period_i = CB'(10);
        bus.dir_i    = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (t == 4) rstn = 1'b0;
            @(negedge clk);
            if (t == 3) check("pre_reset_step", bus.step_o, 1);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("post_reset_done", bus.done_o, 0);
            check("post_reset_step", bus.step_o, 0);
        end
        run_move(3, 10, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int n, p, kind, s;
            n    = $urandom_range(0, 5);
            p    = $urandom_range(1, 12);
            kind = $urandom_range(0, 3);
            s    = $urandom_range(0, 1 + DS + n * 12 + 2);
            run_move(n, p, 1'($urandom_range(0, 1)), s, kind, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
